cmd_cfg_multi: RTL

CMD_CFG_MULTI -- requirements
Module: cmd_cfg_multi

---
 rtl/cmd_cfg_pkg.sv | 46 ++++
 rtl/cmd_cfg_multi_cal_timer.sv | 24 ++
 rtl/cmd_cfg_multi.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cmd_cfg_pkg.sv
// Shared opcodes, response codes, FSM states and opcode decoder for cmd_cfg_multi.
package cmd_cfg_pkg;

    localparam logic [7:0] OP_SET_CH_BASE = 8'h20;
    localparam logic [7:0] OP_SET_THRST   = 8'h05;
    localparam logic [7:0] OP_CALIBRATE   = 8'h06;
    localparam logic [7:0] OP_EMER_LAND   = 8'h07;
    localparam logic [7:0] OP_MTRS_OFF    = 8'h08;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_NAK = 8'h5A;
    localparam logic [7:0] RESP_TMO = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        SPIN,
        CAL_WAIT,
        RAMP,
        RESP
    } state_t;

    typedef enum logic [2:0] {
        DEC_SET_CH,
        DEC_THRST,
        DEC_CAL,
        DEC_EMER,
        DEC_MOFF,
        DEC_INVALID
    } op_t;

    // Channel opcodes form a window 0x20..0x20+n_ch-1; everything unlisted is invalid.
    function automatic op_t decode_op(input logic [7:0] cmd, input int n_ch);
        int idx;
        idx = int'(cmd) - int'(OP_SET_CH_BASE);
        if (idx >= 0 && idx < n_ch) return DEC_SET_CH;
        case (cmd)
            OP_SET_THRST: return DEC_THRST;
            OP_CALIBRATE: return DEC_CAL;
            OP_EMER_LAND: return DEC_EMER;
            OP_MTRS_OFF:  return DEC_MOFF;
            default:      return DEC_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/cmd_cfg_multi_cal_timer.sv
// Free-running up-counter used for both the spin-up delay and the calibration timeout.
module cal_timer #(
    parameter int W = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic full
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign full = &count;

endmodule

// File: rtl/cmd_cfg_multi.sv
// Command decoder / configuration block: setpoints, thrust, calibration sequencing.
// Define CMD_CFG_MULTI_RAMP_EN to make EMER_LAND ramp thrust down instead of cutting it.
module cmd_cfg_multi
    import cmd_cfg_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DW        = 16,
    parameter int THR_W     = 9,
    parameter int SPIN_W    = 9,
    parameter int TO_W      = 12,
    parameter int RAMP_STEP = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_rdy,
    input  logic [7:0]           cmd,
    input  logic [DW-1:0]        data,
    input  logic                 cal_done,
    output logic                 clr_cmd_rdy,
    output logic [7:0]           resp,
    output logic                 send_resp,
    output logic [N_CH*DW-1:0]   setpt,
    output logic [THR_W-1:0]     thrst,
    output logic                 strt_cal,
    output logic                 inertial_cal,
    output logic                 motors_off,
    output logic                 busy
);

    localparam logic [THR_W-1:0] THR_MAX = '1;
`ifdef CMD_CFG_MULTI_RAMP_EN
    localparam logic [THR_W-1:0] STEP = THR_W'(RAMP_STEP);
`endif

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          cmd_q;
    logic [DW-1:0]       data_q;
    logic [N_CH*DW-1:0]  setpt_q;
    logic [THR_W-1:0]    thrst_q;
    logic                motors_off_q;
    logic [7:0]          resp_q;
    logic [7:0]          resp_nxt;
    logic                cal_seq;
    op_t                 op;
    logic [7:0]          ch_idx;
    logic                thr_over;
    logic                timers_clr;
    logic                spin_full;
    logic                to_full;

    assign op         = decode_op(cmd_q, N_CH);
    assign ch_idx     = cmd_q - OP_SET_CH_BASE;
    assign thr_over   = |(data_q >> THR_W);
    assign timers_clr = (state == DECODE) && (op == DEC_CAL);

    cal_timer #(.W(SPIN_W)) u_spin_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timers_clr),
        .en   (state == SPIN),
        .full (spin_full)
    );

    cal_timer #(.W(TO_W)) u_timeout_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timers_clr),
        .en   (state == CAL_WAIT),
        .full (to_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        resp_nxt  = RESP_ACK;
        case (state)
            IDLE: begin
                if (cmd_rdy) state_nxt = DECODE;
            end
            DECODE: begin
                case (op)
                    DEC_CAL: state_nxt = SPIN;
`ifdef CMD_CFG_MULTI_RAMP_EN
                    DEC_EMER: state_nxt = (thrst_q == '0) ? RESP : RAMP;
`endif
                    DEC_INVALID: begin
                        state_nxt = RESP;
                        resp_nxt  = RESP_NAK;
                    end
                    default: state_nxt = RESP;
                endcase
            end
            SPIN: begin
                if (spin_full) state_nxt = CAL_WAIT;
            end
            // cal_done is checked first so it wins a tie with the timeout.
            CAL_WAIT: begin
                if (cal_done) begin
                    state_nxt = RESP;
                end else if (to_full) begin
                    state_nxt = RESP;
                    resp_nxt  = RESP_TMO;
                end
            end
`ifdef CMD_CFG_MULTI_RAMP_EN
            RAMP: begin
                if (thrst_q == '0) state_nxt = RESP;
            end
`endif
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q        <= '0;
            data_q       <= '0;
            setpt_q      <= '0;
            thrst_q      <= '0;
            motors_off_q <= 1'b1;
            resp_q       <= RESP_ACK;
            cal_seq      <= 1'b0;
        end else begin
            cal_seq <= (state == CAL_WAIT);
            if (state_nxt == RESP) resp_q <= resp_nxt;
            case (state)
                IDLE: begin
                    if (cmd_rdy) begin
                        cmd_q  <= cmd;
                        data_q <= data;
                    end
                end
                DECODE: begin
                    case (op)
                        DEC_SET_CH: begin
                            for (int i = 0; i < N_CH; i++) begin
                                if (ch_idx == 8'(i)) setpt_q[i*DW +: DW] <= data_q;
                            end
                        end
                        DEC_THRST: thrst_q <= thr_over ? THR_MAX : data_q[THR_W-1:0];
                        DEC_CAL:   motors_off_q <= 1'b0;
                        DEC_EMER: begin
                            setpt_q <= '0;
`ifndef CMD_CFG_MULTI_RAMP_EN
                            thrst_q <= '0;
`endif
                        end
                        DEC_MOFF:  motors_off_q <= 1'b1;
                        default: ;
                    endcase
                end
                CAL_WAIT: begin
                    if (!cal_done && to_full) motors_off_q <= 1'b1;
                end
`ifdef CMD_CFG_MULTI_RAMP_EN
                RAMP: thrst_q <= (thrst_q > STEP) ? thrst_q - STEP : '0;
`endif
                default: ;
            endcase
        end
    end

    assign clr_cmd_rdy  = (state == IDLE) && cmd_rdy && !rst;
    assign send_resp    = (state == RESP);
    assign strt_cal     = (state == SPIN) && spin_full;
    // cal_seq marks the RESP cycle that closes a calibration sequence.
    assign inertial_cal = (state == SPIN) || (state == CAL_WAIT) || ((state == RESP) && cal_seq);
    assign busy         = (state != IDLE);
    assign resp         = resp_q;
    assign setpt        = setpt_q;
    assign thrst        = thrst_q;
    assign motors_off   = motors_off_q;

endmodule
